// File: rtl/anita3_scaler_pkg.sv
// ============================================================================
// Module   : anita3_scaler_pkg
// Brief    : Shared constants, state encoding and scaler address table.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package anita3_scaler_pkg;

    localparam int unsigned SCAL_NUM_WORDS   = 35;
    localparam int unsigned SCAL_FRAME_WORDS = 36;

    localparam logic [7:0] SCAL_HEADER_TAG_DEFAULT = 8'hA3;

    localparam logic [5:0] SCAL_ADDR_REFPULSE = 6'h20;
    localparam logic [5:0] SCAL_ADDR_SECDEAD  = 6'h21;
    localparam logic [5:0] SCAL_ADDR_C3PO     = 6'h27;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SWEEP  = 2'd2,
        ST_STREAM = 2'd3
    } scal_state_t;

    // Sweep index to bank address; indices past the table map to 0.
    function automatic logic [5:0] scal_addr_of(input logic [5:0] idx);
        logic [5:0] addr;
        if (idx < 6'd32) begin
            addr = idx;
        end else if (idx == 6'd32) begin
            addr = SCAL_ADDR_REFPULSE;
        end else if (idx == 6'd33) begin
            addr = SCAL_ADDR_SECDEAD;
        end else if (idx == 6'd34) begin
            addr = SCAL_ADDR_C3PO;
        end else begin
            addr = 6'h00;
        end
        return addr;
    endfunction

endpackage

`default_nettype wire

// File: rtl/anita3_scaler_snapshot.sv
// ============================================================================
// Module   : anita3_scaler_snapshot
// Brief    : 35x32 snapshot buffer, one synchronous write port, one read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module anita3_scaler_snapshot
    import anita3_scaler_pkg::*;
(
    input  logic        clk,
    input  logic        wr_en,
    input  logic [5:0]  wr_idx,
    input  logic [31:0] wr_data,
    input  logic [5:0]  rd_idx,
    output logic [31:0] rd_data
);

    logic [31:0] mem [0:SCAL_NUM_WORDS-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Out-of-range reads occur once the final word has been prefetched.
    assign rd_data = (rd_idx < 6'(SCAL_NUM_WORDS)) ? mem[rd_idx] : 32'h0;

endmodule

`default_nettype wire

// File: rtl/anita3_scaler_reader.sv
// ============================================================================
// Module   : anita3_scaler_reader
// Brief    : PPS-triggered scaler sweep into a snapshot, streamed as a frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module anita3_scaler_reader
    import anita3_scaler_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [7:0]  HEADER_TAG    = SCAL_HEADER_TAG_DEFAULT
) (
    input  logic        clk33_i,
    input  logic        rst_i,
    input  logic        pps_i,
    output logic [5:0]  scal_addr_o,
    input  logic [31:0] scal_dat_i,
    output logic [31:0] dat_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        last_o,
    output logic        busy_o,
    output logic [7:0]  overrun_o
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam logic [5:0] SWEEP_END   = 6'(SCAL_NUM_WORDS);
    localparam logic [5:0] LAST_RD_PTR = 6'(SCAL_FRAME_WORDS - 1);

    scal_state_t state;
    scal_state_t state_next;

    logic        pps_q;
    logic        pps_q2;
    logic        pps_edge;
    logic [3:0]  settle_cnt;
    logic [5:0]  sweep_idx;
    logic [5:0]  rd_ptr;
    logic [31:0] prefetch;
    logic [31:0] rd_data;
    logic [15:0] seq;
    logic        wr_en;
    logic        handshake;

    assign wr_en     = (state == ST_SWEEP) && (sweep_idx < SWEEP_END);
    assign handshake = valid_o && ready_i;

    anita3_scaler_snapshot u_snapshot (
        .clk     (clk33_i),
        .wr_en   (wr_en),
        .wr_idx  (sweep_idx),
        .wr_data (scal_dat_i),
        .rd_idx  (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk33_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:   if (pps_edge) state_next = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == 4'd1) state_next = ST_SWEEP;
            ST_SWEEP:  if (sweep_idx == SWEEP_END) state_next = ST_STREAM;
            ST_STREAM: if (handshake && last_o) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk33_i) begin
        if (rst_i) begin
            pps_q       <= 1'b0;
            pps_q2      <= 1'b0;
            pps_edge    <= 1'b0;
            settle_cnt  <= 4'd0;
            sweep_idx   <= 6'd0;
            rd_ptr      <= 6'd0;
            prefetch    <= 32'h0;
            seq         <= 16'h0;
            scal_addr_o <= 6'h0;
            dat_o       <= 32'h0;
            valid_o     <= 1'b0;
            last_o      <= 1'b0;
            busy_o      <= 1'b0;
            overrun_o   <= 8'h0;
        end else begin
            pps_q    <= pps_i;
            pps_q2   <= pps_q;
            pps_edge <= pps_q & ~pps_q2;
            busy_o   <= (state_next != ST_IDLE);

            // Any edge that cannot start a frame is a dropped PPS.
            if (pps_edge && (state != ST_IDLE) && (overrun_o != 8'hFF)) begin
                overrun_o <= overrun_o + 8'd1;
            end

            unique case (state)
                ST_IDLE: begin
                    if (pps_edge) begin
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                    if (state_next == ST_SWEEP) begin
                        sweep_idx   <= 6'd0;
                        rd_ptr      <= 6'd0;
                        scal_addr_o <= scal_addr_of(6'd0);
                    end
                end
                ST_SWEEP: begin
                    sweep_idx   <= sweep_idx + 6'd1;
                    scal_addr_o <= scal_addr_of(sweep_idx + 6'd1);
                    if (state_next == ST_STREAM) begin
                        dat_o    <= {HEADER_TAG, overrun_o, seq};
                        valid_o  <= 1'b1;
                        last_o   <= 1'b0;
                        prefetch <= rd_data;
                        rd_ptr   <= 6'd1;
                    end
                end
                ST_STREAM: begin
                    if (handshake) begin
                        if (last_o) begin
                            valid_o <= 1'b0;
                            last_o  <= 1'b0;
                            seq     <= seq + 16'd1;
                        end else begin
                            // prefetch holds buf[rd_ptr-1]; refill it behind each accept.
                            dat_o    <= prefetch;
                            last_o   <= (rd_ptr == LAST_RD_PTR);
                            prefetch <= rd_data;
                            rd_ptr   <= rd_ptr + 6'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_anita3_scaler_reader.sv
// ============================================================================
// Module   : tb_anita3_scaler_reader
// Brief    : Directed/randomised frame checks against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_anita3_scaler_reader;

    localparam int S = 4;

    logic        clk33_i = 1'b0;
    logic        rst_i   = 1'b1;
    logic        pps_i   = 1'b0;
    logic        ready_i = 1'b0;
    logic [5:0]  scal_addr_o;
    logic [31:0] scal_dat_i;
    logic [31:0] dat_o;
    logic        valid_o;
    logic        last_o;
    logic        busy_o;
    logic [7:0]  overrun_o;

    logic [31:0] dat_key = 32'h5A000000;
    assign scal_dat_i = {26'h0, scal_addr_o} ^ dat_key;

    anita3_scaler_reader #(
        .SETTLE_CYCLES (S),
        .HEADER_TAG    (8'hA3)
    ) dut (
        .clk33_i     (clk33_i),
        .rst_i       (rst_i),
        .pps_i       (pps_i),
        .scal_addr_o (scal_addr_o),
        .scal_dat_i  (scal_dat_i),
        .dat_o       (dat_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .last_o      (last_o),
        .busy_o      (busy_o),
        .overrun_o   (overrun_o)
    );

    always #15 clk33_i = ~clk33_i;

    int total = 0;
    int bad   = 0;

    int          exp_ovr = 0;
    int          exp_seq = 0;
    logic [31:0] exp_words [36];
    int          addr_list [35];

    task automatic tick();
        @(posedge clk33_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Frame as the bank looked during the sweep: header then table order.
    task automatic build_expected(input logic [31:0] key);
        exp_words[0] = {8'hA3, 8'(exp_ovr), 16'(exp_seq)};
        for (int k = 0; k < 35; k++) begin
            exp_words[k+1] = (32'(addr_list[k]) & 32'h3F) ^ key;
        end
    endtask

    task automatic pulse_pps();
        pps_i = 1'b1;
        tick();
        tick();
        pps_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_addr"},    32'(scal_addr_o), 32'h0);
        check({pfx, "_dat"},     dat_o,            32'h0);
        check({pfx, "_valid"},   32'(valid_o),     32'h0);
        check({pfx, "_last"},    32'(last_o),      32'h0);
        check({pfx, "_busy"},    32'(busy_o),      32'h0);
        check({pfx, "_overrun"}, 32'(overrun_o),   32'h0);
    endtask

    // mode 0: ready always high; mode 1: ready random each cycle.
    task automatic collect(input int mode, input int start_idx, input int end_idx);
        int          idx;
        int          guard;
        int          cycles;
        logic        seen;
        logic        stalled;
        logic [31:0] held_d;
        logic        held_l;
        idx     = start_idx;
        guard   = 0;
        cycles  = 0;
        seen    = 1'b0;
        stalled = 1'b0;
        held_d  = 32'h0;
        held_l  = 1'b0;
        while (idx < end_idx && guard < 3000) begin
            ready_i = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (valid_o) seen = 1'b1;
            if (seen) cycles++;
            if (valid_o) begin
                if (stalled) begin
                    check("stall_dat_stable",  dat_o,         held_d);
                    check("stall_last_stable", 32'(last_o),   32'(held_l));
                end
                if (ready_i) begin
                    check($sformatf("word%0d", idx), dat_o, exp_words[idx]);
                    check($sformatf("last%0d", idx), 32'(last_o), 32'(idx == 35));
                    idx++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held_d  = dat_o;
                    held_l  = last_o;
                end
            end
            tick();
            guard++;
        end
        ready_i = 1'b0;
        check("frame_word_count", 32'(idx), 32'(end_idx));
        if (mode == 0) begin
            check("no_bubbles", 32'(cycles), 32'(end_idx - start_idx));
        end
        if (end_idx == 36) begin
            check("valid_fall", 32'(valid_o), 32'h0);
            check("busy_fall",  32'(busy_o),  32'h0);
            exp_seq = (exp_seq + 1) % 65536;
        end
    endtask

    initial begin
        int n;
        for (int k = 0; k < 32; k++) addr_list[k] = k;
        addr_list[32] = 32'h20;
        addr_list[33] = 32'h21;
        addr_list[34] = 32'h27;

        // Reset
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        check_reset_outputs("reset");

        // Basic frame with latency checks
        dat_key = 32'h5A000000;
        build_expected(dat_key);
        ready_i = 1'b1;
        pps_i   = 1'b1;
        n = 0;
        while (!valid_o && n < 200) begin
            tick();
            n++;
            if (n == 2) begin
                pps_i = 1'b0;
                check("busy_before", 32'(busy_o), 32'h0);
            end
            if (n == 3)          check("busy_rise",       32'(busy_o),      32'h1);
            if (n == 3 + S + 1)  check("sweep_addr1",     32'(scal_addr_o), 32'h01);
            if (n == 3 + S + 34) check("sweep_addr_c3po", 32'(scal_addr_o), 32'h27);
        end
        check("first_valid_latency", 32'(n), 32'(3 + S + 36));
        collect(0, 0, 36);

        // Backpressure, second frame carries seq 1
        build_expected(dat_key);
        pulse_pps();
        collect(1, 0, 36);

        // Overrun while stalled after the header
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        exp_ovr = 0;
        exp_seq = 0;
        dat_key = $urandom;
        build_expected(dat_key);
        pulse_pps();
        collect(0, 0, 1);
        for (int p = 0; p < 3; p++) begin
            pulse_pps();
            exp_ovr++;
        end
        check("overrun_three", 32'(overrun_o), 32'(exp_ovr));
        collect(0, 1, 36);
        build_expected(dat_key);
        pulse_pps();
        collect(0, 0, 36);

        // Saturation
        build_expected(dat_key);
        pulse_pps();
        collect(0, 0, 1);
        for (int p = 0; p < 300; p++) begin
            pulse_pps();
            if (exp_ovr < 255) exp_ovr++;
        end
        check("overrun_saturate", 32'(overrun_o), 32'(exp_ovr));
        collect(1, 1, 36);

        // Snapshot integrity: bank contents change mid-stream
        dat_key = $urandom;
        build_expected(dat_key);
        pulse_pps();
        collect(1, 0, 1);
        dat_key = ~dat_key;
        collect(1, 1, 36);

        // Reset after word 10
        build_expected(dat_key);
        pulse_pps();
        collect(0, 0, 11);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_reset_outputs("midreset");
        exp_ovr = 0;
        exp_seq = 0;
        dat_key = $urandom;
        build_expected(dat_key);
        pulse_pps();
        collect(1, 0, 36);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
